// File: rtl/drum_pkg.sv
// Shared constants and FSM state type for the drum accumulator.
package drum_pkg;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 24;

  typedef enum logic {
    ST_ACC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/drum_sat_add.sv
// Combinational signed adder with overflow detect.
// DRUM_ACCUM_SAT_EN: when defined, an overflowing sum clamps to the signed extreme.
module drum_sat_add #(
  parameter int unsigned ACC_W = 24
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [ACC_W-1:0] MaxPos = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MaxNeg = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] raw;

  // Signed overflow: operands share a sign that the wrapped result does not.
  always_comb begin
    raw   = a_i + b_i;
    ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
`ifdef DRUM_ACCUM_SAT_EN
    if (ovf_o) begin
      sum_o = a_i[ACC_W-1] ? MaxNeg : MaxPos;
    end else begin
      sum_o = raw;
    end
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/drum_accum.sv
// Streaming signed dot-product accumulator behind the drum multiplier.
// Overflow mode selected by DRUM_ACCUM_SAT_EN (saturate when defined, wrap otherwise).
module drum_accum
  import drum_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROD_W-1:0]          in_prod,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [$clog2(LEN+1)-1:0]   out_count,
  output logic                       out_ovf
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LenC = CNT_W'(LEN);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

  assign prod_ext = ACC_W'($signed(in_prod));
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // in_ready_q is only high in ST_ACC, so this also qualifies the state.
  assign beat     = in_valid & in_ready_q;

  drum_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Next-state: accumulate beats, close the vector, release the result.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d       = add_sum;
          cnt_d       = cnt_inc;
          ovf_d       = ovf_q | add_ovf;
          out_sum_d   = add_sum;
          out_count_d = cnt_inc;
          out_ovf_d   = ovf_q | add_ovf;
          if ((cnt_inc == LenC) || in_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_drum_accum.sv
// Directed, table-driven bench for drum_accum plus ACC_W=17 and LEN=1 instances.
module tb_drum_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: defaults (PROD_W=16, ACC_W=24, LEN=8).
  logic        in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_prod = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_sum;
  logic [3:0]  out_count;

  drum_accum u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  // Narrow accumulator instance for overflow.
  logic        o_in_valid = 0, o_in_last = 0, o_out_ready = 0;
  logic [15:0] o_in_prod = '0;
  logic        o_in_ready, o_out_valid, o_out_ovf;
  logic [16:0] o_out_sum;
  logic [3:0]  o_out_count;

  drum_accum #(.ACC_W(17)) u_ovf (
    .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_prod(o_in_prod), .in_last(o_in_last), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_sum(o_out_sum), .out_count(o_out_count), .out_ovf(o_out_ovf)
  );

  // Single-beat vector instance.
  logic        l_in_valid = 0, l_in_last = 0, l_out_ready = 0;
  logic [15:0] l_in_prod = '0;
  logic        l_in_ready, l_out_valid, l_out_ovf;
  logic [23:0] l_out_sum;
  logic [0:0]  l_out_count;

  drum_accum #(.LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_prod(l_in_prod), .in_last(l_in_last), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_sum(l_out_sum), .out_count(l_out_count), .out_ovf(l_out_ovf)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0][15:0] p;
    int               n;
    bit               last;
    int               exp_sum;
    int               exp_cnt;
    int               exp_ovf;
  } vec_t;

  vec_t vecs [5];

  // Push one vector through the main instance and check the result and release.
  task automatic run_vec(input vec_t v, input int idx);
    int guard;
    bit ok;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_prod  = v.p[i];
      in_last  = v.last && (i == v.n - 1);
      guard    = 0;
      do begin
        ok = in_ready;
        tick();
        guard++;
      end while (!ok && guard < 50);
      if (!ok) check($sformatf("vec%0d_beat%0d_accept", idx, i), 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    guard    = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    check($sformatf("vec%0d_valid", idx), int'(out_valid), 1);
    check($sformatf("vec%0d_sum", idx), int'($signed(out_sum)), v.exp_sum);
    check($sformatf("vec%0d_count", idx), int'(out_count), v.exp_cnt);
    check($sformatf("vec%0d_ovf", idx), int'(out_ovf), v.exp_ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("vec%0d_released", idx), int'(out_valid), 0);
    check($sformatf("vec%0d_ready_again", idx), int'(in_ready), 1);
  endtask

  initial begin
    vecs[0] = '{p: {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, n: 8, last: 0,
                exp_sum: 36, exp_cnt: 8, exp_ovf: 0};
    vecs[1] = '{p: {64'h0, 16'h0005, 16'hFFFF, 16'hFFFF, 16'hFFFF}, n: 4, last: 1,
                exp_sum: 2, exp_cnt: 4, exp_ovf: 0};
    vecs[2] = '{p: {{8{16'hFFFF}}}, n: 8, last: 0, exp_sum: -8, exp_cnt: 8, exp_ovf: 0};
    vecs[3] = '{p: {{6{16'h0}}, 16'h8000, 16'h8000}, n: 2, last: 1,
                exp_sum: -65536, exp_cnt: 2, exp_ovf: 0};
    // in_last on the LEN-th beat: one completion only.
    vecs[4] = '{p: {{8{16'd1000}}}, n: 8, last: 1, exp_sum: 8000, exp_cnt: 8, exp_ovf: 0};

    // Reset held for two cycles.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", int'(in_ready), 1);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Latency: 1..8 back-to-back with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_prod = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    check("lat_valid_t1", int'(out_valid), 1);
    check("lat_sum_t1", int'(out_sum), 36);
    check("lat_ready_t1", int'(in_ready), 0);
    tick();
    check("lat_ready_t2", int'(in_ready), 1);
    check("lat_valid_t2", int'(out_valid), 0);
    out_ready = 1'b0;

    // Backpressure: DONE held five cycles with in_valid asserted.
    in_valid = 1'b1;
    in_prod  = 16'd5;
    in_last  = 1'b1;
    tick();
    in_prod = 16'd99;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), int'(out_valid), 1);
      check($sformatf("bp_sum%0d", i), int'(out_sum), 5);
      check($sformatf("bp_count%0d", i), int'(out_count), 1);
      check($sformatf("bp_ready%0d", i), int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    begin
      vec_t v;
      v = '{p: {{6{16'h0}}, 16'd20, 16'd10}, n: 2, last: 1, exp_sum: 30, exp_cnt: 2, exp_ovf: 0};
      run_vec(v, 10);
    end

    // Overflow on the 17-bit instance: three beats of 0x7FFF.
    o_in_valid = 1'b1;
    o_in_prod  = 16'h7FFF;
    for (int i = 0; i < 3; i++) begin
      o_in_last = (i == 2);
      tick();
    end
    o_in_valid = 1'b0;
    o_in_last  = 1'b0;
    check("ovf_valid", int'(o_out_valid), 1);
    check("ovf_flag", int'(o_out_ovf), 1);
    check("ovf_count", int'(o_out_count), 3);
`ifdef DRUM_ACCUM_SAT_EN
    check("ovf_sum", int'($signed(o_out_sum)), 65535);
`else
    check("ovf_sum", int'($signed(o_out_sum)), -32771);
`endif
    o_out_ready = 1'b1;
    tick();
    o_out_ready = 1'b0;
    check("ovf_cleared_ready", int'(o_in_ready), 1);

    // LEN=1: each accepted beat completes without in_last.
    l_in_valid  = 1'b1;
    l_in_prod   = 16'd3;
    l_out_ready = 1'b1;
    tick();
    l_in_valid = 1'b0;
    check("len1_valid_a", int'(l_out_valid), 1);
    check("len1_sum_a", int'(l_out_sum), 3);
    check("len1_count_a", int'(l_out_count), 1);
    tick();
    l_in_valid = 1'b1;
    l_in_prod  = 16'd4;
    tick();
    l_in_valid = 1'b0;
    check("len1_sum_b", int'(l_out_sum), 4);
    check("len1_valid_b", int'(l_out_valid), 1);
    tick();
    l_out_ready = 1'b0;

    // Reset mid-vector discards the partial sum.
    in_valid = 1'b1;
    in_prod  = 16'd100;
    tick();
    in_prod = 16'd200;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("mid_rst_ready", int'(in_ready), 0);
    check("mid_rst_sum", int'(out_sum), 0);
    rst_n = 1'b1;
    tick();
    begin
      vec_t v;
      v = '{p: {{7{16'h0}}, 16'd7}, n: 1, last: 1, exp_sum: 7, exp_cnt: 1, exp_ovf: 0};
      run_vec(v, 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_accum.md
# drum_accum

Streaming signed accumulator that sits directly downstream of the drum approximate multiplier. It accepts one 16-bit product per cycle over a valid/ready handshake and sums a vector of up to LEN products. It then presents the dot-product result, beat count and overflow flag on a second valid/ready handshake. This lets the multiplier datapath build approximate dot products without host-side read-modify-write through the RAM window.

## Interface
Parameters:
- PROD_W, 16: product width. Matches the multiplier output n+m.
- ACC_W, 24: accumulator width. Must be at least PROD_W.
- LEN, 8: maximum beats per vector. Must be at least 1.
- CNT_W, $clog2(LEN+1): beat-count width (derived localparam).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: one clock; reset is synchronous and active-low.
- in_valid, in, 1: in_prod is valid.
- in_ready, out, 1: registered; block accepts a beat this cycle.
- in_prod, in, PROD_W: signed two's-complement product.
- in_last, in, 1: the accepted beat closes the vector early.
- out_valid, out, 1: registered; result is valid.
- out_ready, in, 1: consumer takes the result.
- out_sum, out, ACC_W: signed vector sum.
- out_count, out, CNT_W: beats in the vector, range 1..LEN.
- out_ovf, out, 1: signed overflow occurred at least once in this vector.

## Operation
States:
- ACC: in_ready=1, out_valid=0.
- DONE: in_ready=0, out_valid=1.

Beat acceptance:
- A beat is accepted when in_valid & in_ready.
- On an accepted beat: acc <= acc + sign_extend(in_prod); cnt <= cnt+1.
- Overflow on the add sets sticky ovf.

ACC -> DONE:
- Occurs on an accepted beat where cnt+1 == LEN or in_last=1.
- out_sum, out_count and out_ovf take the values that include this beat.

DONE -> ACC:
- Occurs when out_valid & out_ready.
- acc, cnt and ovf clear to 0 on the same edge.

Holding in DONE:
- out_sum, out_count and out_ovf remain stable while out_ready=0.
- in_valid beats are ignored, not accepted.

Boundary rules:
- in_valid with in_ready=0: no state change; the producer must hold.
- in_last on the LEN-th beat: a single completion, with out_count=LEN.
- LEN=1: every accepted beat completes a vector.
- in_last while in_valid=0: ignored.

Reset:
- Synchronous active-low; applies at any point, including mid-vector and in DONE.
- Values while rst_n=0: state=ACC, in_ready=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, acc=0, cnt=0.
- The first cycle after release has in_ready=1.
- Partial vectors are discarded.

## Timing
- Throughput: one beat per cycle in ACC.
- Minimum per vector: k beats plus 1 DONE cycle when out_ready is held high.
- Latency: the last beat is accepted at edge t; out_valid=1 from t+1 with the final sum.
- With out_ready=1 at t+1: in_ready=1 at t+2, and out_valid=0 at t+2.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

## Configuration
DRUM_ACCUM_SAT_EN controls overflow behaviour:
- Defined: signed overflow clamps acc to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)). Later beats add to the clamped value. out_ovf is set.
- Undefined: acc wraps modulo 2^ACC_W. out_ovf is still set on any signed overflow.
- Handshake and timing are identical in both builds.

## Structure
Package drum_pkg:
- PROD_W_DEF and ACC_W_DEF constants.
- State typedef with members ST_ACC and ST_DONE.

Sub-module drum_sat_add:
- Combinational ACC_W signed add that produces the sum and an overflow flag.
- Applies saturation under DRUM_ACCUM_SAT_EN.

drum_accum holds the FSM, the counter and the output registers.

## Test plan
1. Reset: hold rst_n=0 for 2 cycles. Required: in_ready=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. The first cycle after release has in_ready=1.
2. Full vector (LEN=8): products 1..8 back-to-back, out_ready=1. Required: out_valid one cycle after the 8th beat, out_sum=36, out_count=8, out_ovf=0; in_ready=1 again two cycles after the 8th beat.
3. Early termination: products 0xFFFF, 0xFFFF, 0xFFFF, 0x0005, with in_last on the 4th. Required: out_sum=2, out_count=4.
4. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1. Required: outputs stable, no beats accepted. After out_ready=1, a next vector of 10 and 20 gives out_sum=30.
5. Overflow (ACC_W=17): three beats of 0x7FFF, in_last on the 3rd. Required: out_ovf=1. Without the macro, out_sum=-32771. With DRUM_ACCUM_SAT_EN, out_sum=65535.
6. Reset mid-vector: accept 100 and 200, pulse rst_n=0 for one cycle, then send 7 with in_last. Required: out_sum=7, out_count=1.
